pipelined_shifter: RTL and testbench
====================================

# pipelined_shifter

Parametrised, pipelined barrel shifter that succeeds the 32-bit combinational Shifter in the ALU datapath. It adds a data width parameter, rotate modes and one register stage per shift bit. A valid/ready handshake with backpressure lets it sit between the operand-fetch and writeback stages. Throughput is one operation per cycle; latency is log2(WIDTH) cycles.

## Interface
- WIDTH, 32: data width; power of two, 8 to 64.
- TAG_W, 4: width of the sideband tag carried alongside each operation.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation offered.
- in_ready  output  1  operation accepted when in_valid && in_ready at a clock edge.
- in_a  input  WIDTH  operand to shift.
- in_b  input  WIDTH  shift amount; only bits [LOG2W-1:0] are used, upper bits are ignored.
- in_op  input  3  operation: 0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR, 5–7 illegal.
- in_tag  input  TAG_W  sideband, returned unchanged with the result.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  shifted result.
- out_tag  output  TAG_W  tag of this result.
- out_err  output  1  high when the result came from an illegal op.

## Operation
- LOG2W = $clog2(WIDTH). The pipeline has LOG2W stages.
- Input flip: left ops (SLL, ROL) bit-reverse in_a on entry. All stages then perform right shifts or right rotates.
- Stage k: if amount bit k is set, shift or rotate right by 2^k; otherwise pass through.
- Fill bits per op:
  - SRL and SLL fill with 0.
  - SRA fills with in_a[WIDTH-1], captured at entry and carried down the pipe.
  - ROL and ROR fill with the wrapped-out bits.
- Output flip: the last stage bit-reverses again for left ops.
- Each stage register holds: valid, data, remaining amount bits, op, sign, tag, err.
- Illegal op (5–7): all stages pass the data through, so out_data = in_a and out_err = 1.
- Shift amount 0 returns in_a for every legal op.
- Shift amount WIDTH-1:
  - SLL leaves only in_a[0] at the MSB.
  - SRA returns all sign bits.

## Timing
- Advance condition: adv = !out_valid || out_ready. When adv is high, every stage loads from its predecessor. When adv is low, every stage, including bubbles, holds.
- in_ready = adv (combinational from out_valid and out_ready).
- An op accepted at edge n appears at out_valid/out_data after edge n+LOG2W if adv stays high. Each stall cycle adds one cycle of delay.
- No reordering, drops or duplicates. Bubbles propagate as valid = 0.
- Reset (asynchronous) clears all stage valids, out_valid, out_data, out_tag and out_err to 0 immediately. Any in-flight ops are discarded. in_ready = 1 while reset is held.
- Release of reset is used synchronously. The first acceptance is possible at the first edge after deassertion.
- Holding in_valid with in_ready low is legal. The operation is taken on the first edge with both signals high.

## Structure
- Package shifter_pkg holds:
  - op encodings SH_SLL=3'd0, SH_SRL=3'd1, SH_SRA=3'd2, SH_ROL=3'd3, SH_ROR=3'd4;
  - a helper function is_left(op);
  - a helper function is_legal(op).
- Sub-module shift_stage:
  - parameters WIDTH, TAG_W and a fixed distance DIST = 2^k;
  - contains one register stage with enable adv;
  - the top level instantiates it LOG2W times in a generate loop.
- The bit-reversal logic and adv stay in the top level.

## Test plan
- WIDTH=32, SRA, a=0x80000000, b=31: out_data=0xFFFFFFFF with out_valid exactly 5 cycles after acceptance.
- SLL, a=0x00000001, b=0x23: out_data=0x00000008, because upper amount bits are ignored.
- ROR, a=0x12345678, b=8: out_data=0x78123456. ROL, same a, b=4: out_data=0x23456781. Both results appear on back-to-back cycles.
- Stream of 6 ops with tags 0–5, out_ready low for 2 cycles mid-stream:
  - in_ready is low for those 2 cycles;
  - all 6 results emerge in order with matching tags, none lost or duplicated.
- Illegal op 3'd6, a=0xDEADBEEF: out_data=0xDEADBEEF, out_err=1. The next legal op has out_err=0.
- Reset asserted with 3 ops in flight:
  - out_valid drops to 0 immediately;
  - none of the 3 ops appear after release.
- Separate WIDTH=8 instance, SRL, a=0x80, b=7: out_data=0x01 after 3 cycles.

Source files
------------

// File: rtl/pipelined_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encodings and
// small decode helpers used by the top level and by every shift stage.
package shifter_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] SH_SLL = 3'd0;
  localparam logic [OP_W-1:0] SH_SRL = 3'd1;
  localparam logic [OP_W-1:0] SH_SRA = 3'd2;
  localparam logic [OP_W-1:0] SH_ROL = 3'd3;
  localparam logic [OP_W-1:0] SH_ROR = 3'd4;

  // Left ops are executed as right ops on a bit-reversed operand.
  function automatic logic is_left(input logic [OP_W-1:0] op);
    return (op == SH_SLL) || (op == SH_ROL);
  endfunction

  function automatic logic is_legal(input logic [OP_W-1:0] op);
    return op <= SH_ROR;
  endfunction

endpackage

// File: rtl/pipelined_shifter_if.sv
// Valid/ready bus of the pipelined shifter.
//   in_*  : operation offered by the producer (in_ready returned by the shifter)
//   out_* : result presented to the consumer (out_ready returned by the consumer)
// master = producer/consumer side, slave = shifter side.
interface pipelined_shifter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  modport master (
    output in_valid, in_a, in_b, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_err
  );
endinterface

// File: rtl/pipelined_shifter_shift_stage.sv
// One pipeline stage of the barrel shifter: conditionally shifts/rotates right by a
// fixed distance DIST and registers the result together with its sideband.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   adv_i        : pipeline advance; when low the stage holds (bubbles included)
//   *_i          : predecessor stage (valid, data, amount, op, sign, tag, err)
//   *_o          : registered copy after this stage's shift
module shift_stage
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned DIST  = 1,
  localparam int unsigned LOG2W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             adv_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [LOG2W-1:0] amt_i,
  input  logic [OP_W-1:0]  op_i,
  input  logic             sign_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             err_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [LOG2W-1:0] amt_o,
  output logic [OP_W-1:0]  op_o,
  output logic             sign_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             err_o
);

  localparam int unsigned BIT = $clog2(DIST);

  logic [DIST-1:0]  fill;
  logic [WIDTH-1:0] data_d;

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [LOG2W-1:0] amt_q;
  logic [OP_W-1:0]  op_q;
  logic             sign_q;
  logic [TAG_W-1:0] tag_q;
  logic             err_q;

  // Bits entering at the top: wrapped-out bits for rotates, sign for SRA, else zero.
  always_comb begin
    fill = '0;
    case (op_i)
      SH_ROL, SH_ROR: fill = data_i[DIST-1:0];
      SH_SRA:         fill = {DIST{sign_i}};
      default:        fill = '0;
    endcase
    data_d = data_i;
    if (amt_i[BIT] && is_legal(op_i)) begin
      data_d = {fill, data_i[WIDTH-1:DIST]};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
      op_q    <= '0;
      sign_q  <= 1'b0;
      tag_q   <= '0;
      err_q   <= 1'b0;
    end else if (adv_i) begin
      valid_q <= valid_i;
      data_q  <= data_d;
      amt_q   <= amt_i;
      op_q    <= op_i;
      sign_q  <= sign_i;
      tag_q   <= tag_i;
      err_q   <= err_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign amt_o   = amt_q;
  assign op_o    = op_q;
  assign sign_o  = sign_q;
  assign tag_o   = tag_q;
  assign err_o   = err_q;

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR) with valid/ready handshake.
// Left ops bit-reverse the operand on entry and again on exit so every stage only
// shifts/rotates right. LOG2W shift stages followed by an output register give a
// latency of LOG2W cycles from acceptance; the whole pipe stalls on backpressure.
//   clk   : clock
//   reset : asynchronous active-high reset, clears all valids and outputs
//   bus   : slave side of pipelined_shifter_if (in_* request, out_* result)
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input logic               clk,
  input logic               reset,
  pipelined_shifter_if.slave bus
);

  localparam int unsigned LOG2W = $clog2(WIDTH);

  logic adv;

  // Index 0 is the pipe entry, index k+1 is the register of stage k.
  logic             st_valid [LOG2W+1];
  logic [WIDTH-1:0] st_data  [LOG2W+1];
  logic [LOG2W-1:0] st_amt   [LOG2W+1];
  logic [OP_W-1:0]  st_op    [LOG2W+1];
  logic             st_sign  [LOG2W+1];
  logic [TAG_W-1:0] st_tag   [LOG2W+1];
  logic             st_err   [LOG2W+1];

  logic [WIDTH-1:0] entry_data;
  logic [WIDTH-1:0] out_data_d;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [TAG_W-1:0] out_tag_q;
  logic             out_err_q;

  // Whole pipe moves together; bubbles hold too, so in_ready depends only on the output.
  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv;

  always_comb begin
    entry_data = bus.in_a;
    if (is_left(bus.in_op)) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        entry_data[i] = bus.in_a[WIDTH-1-i];
      end
    end
  end

  assign st_valid[0] = bus.in_valid;
  assign st_data[0]  = entry_data;
  assign st_amt[0]   = bus.in_b[LOG2W-1:0];
  assign st_op[0]    = bus.in_op;
  assign st_sign[0]  = bus.in_a[WIDTH-1];
  assign st_tag[0]   = bus.in_tag;
  assign st_err[0]   = !is_legal(bus.in_op);

  for (genvar k = 0; k < LOG2W; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W),
      .DIST  (2 ** k)
    ) u_stage (
      .clk_i   (clk),
      .rst_i   (reset),
      .adv_i   (adv),
      .valid_i (st_valid[k]),
      .data_i  (st_data[k]),
      .amt_i   (st_amt[k]),
      .op_i    (st_op[k]),
      .sign_i  (st_sign[k]),
      .tag_i   (st_tag[k]),
      .err_i   (st_err[k]),
      .valid_o (st_valid[k+1]),
      .data_o  (st_data[k+1]),
      .amt_o   (st_amt[k+1]),
      .op_o    (st_op[k+1]),
      .sign_o  (st_sign[k+1]),
      .tag_o   (st_tag[k+1]),
      .err_o   (st_err[k+1])
    );
  end

  // Undo the entry reversal for left ops.
  always_comb begin
    out_data_d = st_data[LOG2W];
    if (is_left(st_op[LOG2W])) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        out_data_d[i] = st_data[LOG2W][WIDTH-1-i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_err_q   <= 1'b0;
    end else if (adv) begin
      out_valid_q <= st_valid[LOG2W];
      out_data_q  <= out_data_d;
      out_tag_q   <= st_tag[LOG2W];
      out_err_q   <= st_err[LOG2W];
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.out_err   = out_err_q;

  // Upper amount bits are ignored by design; the last stage's amount/sign have no consumer.
  logic unused_sig;
  assign unused_sig = ^{bus.in_b[WIDTH-1:LOG2W], st_amt[LOG2W], st_sign[LOG2W]};

endmodule

// File: tb/tb_pipelined_shifter.sv
module tb_pipelined_shifter;
  import shifter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipelined_shifter_if #(.WIDTH(32), .TAG_W(4)) bus ();
  pipelined_shifter_if #(.WIDTH(8),  .TAG_W(4)) bus8 ();

  pipelined_shifter #(.WIDTH(32), .TAG_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  pipelined_shifter #(.WIDTH(8),  .TAG_W(4)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    logic        err;
    int          acc;
    int          lat;   // 0: latency not checked
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Scoreboard monitors: a transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      exp_t e;
      if (q32.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected32: got data %h tag %0d, expected no result", bus.out_data,
                 bus.out_tag);
      end else begin
        e = q32.pop_front();
        chk("data32", bus.out_data, e.data);
        chk("tag32", 32'(bus.out_tag), 32'(e.tag));
        chk("err32", 32'(bus.out_err), 32'(e.err));
        if (e.lat != 0) chk("lat32", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  always @(negedge clk) begin
    if (bus8.out_valid === 1'b1 && bus8.out_ready === 1'b1) begin
      exp_t e;
      if (q8.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected8: got data %h, expected no result", bus8.out_data);
      end else begin
        e = q8.pop_front();
        chk("data8", 32'(bus8.out_data), e.data);
        chk("tag8", 32'(bus8.out_tag), 32'(e.tag));
        chk("err8", 32'(bus8.out_err), 32'(e.err));
        if (e.lat != 0) chk("lat8", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag, input logic [31:0] exp, input logic err,
                      input int lat);
    int n = 0;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept32: got in_ready low for 100 cycles, expected acceptance");
    end else begin
      @(posedge clk);
      #1;
      e.data = exp; e.tag = tag; e.err = err; e.acc = cyc; e.lat = lat;
      q32.push_back(e);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] tag, input logic [7:0] exp, input int lat);
    int n = 0;
    exp_t e;
    bus8.in_valid = 1'b1;
    bus8.in_op    = op;
    bus8.in_a     = a;
    bus8.in_b     = b;
    bus8.in_tag   = tag;
    @(negedge clk);
    while (!bus8.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus8.in_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept8: got in_ready low for 100 cycles, expected acceptance");
    end else begin
      @(posedge clk);
      #1;
      e.data = 32'(exp); e.tag = tag; e.err = 1'b0; e.acc = cyc; e.lat = lat;
      q8.push_back(e);
    end
    bus8.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q32.size() != 0 || q8.size() != 0) && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (q32.size() != 0 || q8.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d/%0d results outstanding, expected 0", q32.size(), q8.size());
      q32.delete();
      q8.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 0; bus.in_a = 0; bus.in_b = 0; bus.in_op = 0; bus.in_tag = 0;
    bus.out_ready = 1;
    bus8.in_valid = 0; bus8.in_a = 0; bus8.in_b = 0; bus8.in_op = 0; bus8.in_tag = 0;
    bus8.out_ready = 1;
    reset = 1'b1;
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
    chk("rst_out_err", 32'(bus.out_err), 32'd0);
    chk("rst_out_valid8", 32'(bus8.out_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Basic ops, back-to-back, exact 5-cycle latency each.
    send(SH_SRA, 32'h8000_0000, 32'd31,   4'd1, 32'hFFFF_FFFF, 1'b0, 5);
    send(SH_SLL, 32'h0000_0001, 32'h23,   4'd2, 32'h0000_0008, 1'b0, 5);
    send(SH_ROR, 32'h1234_5678, 32'd8,    4'd3, 32'h7812_3456, 1'b0, 5);
    send(SH_ROL, 32'h1234_5678, 32'd4,    4'd4, 32'h2345_6781, 1'b0, 5);
    send(SH_SLL, 32'hA5A5_A5A5, 32'd0,    4'd5, 32'hA5A5_A5A5, 1'b0, 5);
    send(SH_SLL, 32'h0000_0003, 32'd31,   4'd6, 32'h8000_0000, 1'b0, 5);
    send(SH_SRL, 32'h8000_0000, 32'd31,   4'd7, 32'h0000_0001, 1'b0, 5);
    send(SH_SRA, 32'h7000_0000, 32'd4,    4'd8, 32'h0700_0000, 1'b0, 5);
    send(SH_ROR, 32'h1234_5678, 32'd0,    4'd9, 32'h1234_5678, 1'b0, 5);
    send(SH_ROL, 32'h8000_0001, 32'd1,    4'd10, 32'h0000_0003, 1'b0, 5);
    send(SH_SRA, 32'hF000_0000, 32'd0,    4'd11, 32'hF000_0000, 1'b0, 5);
    send(3'd6,   32'hDEAD_BEEF, 32'd5,    4'd12, 32'hDEAD_BEEF, 1'b1, 5);
    send(SH_SRL, 32'h0000_00F0, 32'd4,    4'd13, 32'h0000_000F, 1'b0, 5);
    drain();

    // Stream of six with a two-cycle output stall while op 5 is waiting.
    fork
      begin
        send(SH_SLL, 32'd1, 32'd0, 4'd0, 32'h01, 1'b0, 0);
        send(SH_SLL, 32'd1, 32'd1, 4'd1, 32'h02, 1'b0, 0);
        send(SH_SLL, 32'd1, 32'd2, 4'd2, 32'h04, 1'b0, 0);
        @(posedge clk);
        #1;
        send(SH_SLL, 32'd1, 32'd3, 4'd3, 32'h08, 1'b0, 0);
        send(SH_SLL, 32'd1, 32'd4, 4'd4, 32'h10, 1'b0, 0);
        send(SH_SLL, 32'd1, 32'd5, 4'd5, 32'h20, 1'b0, 0);
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (2) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three ops in flight; none may emerge afterwards.
    bus.out_ready = 1'b0;
    send(SH_SRL, 32'hFFFF_0000, 32'd4, 4'd7, 32'h0FFF_F000, 1'b0, 0);
    send(SH_SRL, 32'hFFFF_0000, 32'd8, 4'd8, 32'h00FF_FF00, 1'b0, 0);
    send(SH_SRL, 32'hFFFF_0000, 32'd12, 4'd9, 32'h000F_FFF0, 1'b0, 0);
    begin
      int n = 0;
      while (!bus.out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    chk("pre_reset_out_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_out_data", bus.out_data, 32'd0);
    chk("reset_out_err", 32'(bus.out_err), 32'd0);
    q32.delete();
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("post_reset_out_valid", 32'(bus.out_valid), 32'd0);

    // 8-bit instance, 3-cycle latency.
    send8(SH_SRL, 8'h80, 8'd7,  4'd1, 8'h01, 3);
    send8(SH_SRA, 8'h80, 8'd7,  4'd2, 8'hFF, 3);
    send8(SH_ROL, 8'h81, 8'd1,  4'd3, 8'h03, 3);
    send8(SH_SLL, 8'h81, 8'h0F, 4'd4, 8'h80, 3);
    send8(SH_ROR, 8'h81, 8'd2,  4'd5, 8'h60, 3);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
